// File: rtl/spike_rate_decoder_if.sv
// Spike-decoder bus: spike input, decode enable, and the registered window results.
// valid is a one-cycle pulse with no ready; consumers must capture results on that cycle.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 4
);
  logic             en;
  logic [7:0]       spikes;
  logic [2:0]       winner;
  logic [CNT_W-1:0] winner_count;
  logic [CNT_W+2:0] total;
  logic             valid;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output en, spikes,
    input  winner, winner_count, total, valid, busy, state
  );

  modport slave (
    input  en, spikes,
    output winner, winner_count, total, valid, busy, state
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes per lane over a 2^WINDOW_LOG2-sample window and reports the busiest lane.
// Optional macro SPIKE_DECODER_SATURATE_EN: lane counters saturate instead of wrapping.
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 4,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_rate_decoder_if.slave   bus
);

  localparam int TOT_W = CNT_W + 3;
  localparam logic [WINDOW_LOG2-1:0] LAST_SAMPLE = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt      [8];
  logic [CNT_W-1:0]       cnt_next [8];
  logic [WINDOW_LOG2-1:0] sample_cnt, sample_next;
  logic                   load_result;

  logic [2:0]             arg_idx;
  logic [CNT_W-1:0]       arg_cnt;
  logic [TOT_W-1:0]       sum;

  logic [2:0]             winner_r;
  logic [CNT_W-1:0]       winner_count_r;
  logic [TOT_W-1:0]       total_r;
  logic                   valid_r;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic s);
`ifdef SPIKE_DECODER_SATURATE_EN
    if (s && (c != '1)) return c + 1'b1;
    else                return c;
`else
    return c + CNT_W'(s);
`endif
  endfunction

  // Strict greater-than scan from lane 0 keeps the lowest index on ties.
  always_comb begin
    arg_idx = '0;
    arg_cnt = '0;
    sum     = '0;
    for (int i = 0; i < 8; i++) begin
      if (cnt[i] > arg_cnt) begin
        arg_idx = 3'(i);
        arg_cnt = cnt[i];
      end
      sum = sum + TOT_W'(cnt[i]);
    end
  end

  always_comb begin
    state_next  = state;
    sample_next = sample_cnt;
    load_result = 1'b0;
    for (int i = 0; i < 8; i++) cnt_next[i] = cnt[i];

    case (state)
      IDLE: begin
        for (int i = 0; i < 8; i++) cnt_next[i] = '0;
        sample_next = '0;
        if (bus.en) state_next = ACCUM;
      end
      ACCUM: begin
        if (!bus.en) begin
          state_next  = IDLE;
          sample_next = '0;
          for (int i = 0; i < 8; i++) cnt_next[i] = '0;
        end else begin
          for (int i = 0; i < 8; i++) cnt_next[i] = bump(cnt[i], bus.spikes[i]);
          sample_next = sample_cnt + 1'b1;
          if (sample_cnt == LAST_SAMPLE) state_next = REPORT;
        end
      end
      REPORT: begin
        // Spikes in this cycle are dropped; the next window starts from zero.
        load_result = 1'b1;
        sample_next = '0;
        for (int i = 0; i < 8; i++) cnt_next[i] = '0;
        state_next  = bus.en ? ACCUM : IDLE;
      end
      default: begin
        state_next  = IDLE;
        sample_next = '0;
        for (int i = 0; i < 8; i++) cnt_next[i] = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      state      <= state_next;
      sample_cnt <= sample_next;
      for (int i = 0; i < 8; i++) cnt[i] <= cnt_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_r       <= '0;
      winner_count_r <= '0;
      total_r        <= '0;
      valid_r        <= 1'b0;
    end else begin
      valid_r <= load_result;
      if (load_result) begin
        winner_r       <= arg_idx;
        winner_count_r <= arg_cnt;
        total_r        <= sum;
      end
    end
  end

  assign bus.winner       = winner_r;
  assign bus.winner_count = winner_count_r;
  assign bus.total        = total_r;
  assign bus.valid        = valid_r;
  assign bus.busy         = (state != IDLE);
  assign bus.state        = state;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: directed windows, abort, overflow, random windows, reset.
module tb_spike_rate_decoder;

  localparam int CNT_W = 4;
  localparam int WL    = 4;
  localparam int N     = 16;
  localparam int RW    = 3 + CNT_W + CNT_W + 3;

`ifdef SPIKE_DECODER_SATURATE_EN
  localparam logic [RW-1:0] OVF_EXP = {3'd0, 4'd15, 7'd15};
`else
  localparam logic [RW-1:0] OVF_EXP = {3'd0, 4'd0, 7'd0};
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_rate_decoder_if #(.CNT_W(CNT_W)) bus ();

  spike_rate_decoder #(.WINDOW_LOG2(WL), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total_checks = 0;
  int bad_checks   = 0;
  int cyc          = 0;
  int last_valid   = -1;
  int prev_valid   = -1;
  int valids_seen  = 0;
  logic [RW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Result monitor: pop one expectation per valid pulse.
  always @(negedge clk) begin : mon
    logic [RW-1:0] e;
    if (rst_n && bus.valid === 1'b1) begin
      valids_seen++;
      prev_valid = last_valid;
      last_valid = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("winner",       32'(bus.winner),       32'(e[13:11]));
        check("winner_count", 32'(bus.winner_count), 32'(e[10:7]));
        check("total",        32'(bus.total),        32'(e[6:0]));
      end
    end
  end

  function automatic logic [RW-1:0] pack(input int w, input int c, input int t);
    return {3'(w), 4'(c), 7'(t)};
  endfunction

  function automatic logic [7:0] spike_for(input int mode, input int i);
    logic [7:0] s;
    s = 8'h00;
    case (mode)
      0: begin s[3] = (i < 12); s[5] = (i >= 8); end
      1: begin s[1] = (i < 5);  s[6] = (i >= 11); end
      3: s = 8'h01;
      4: s[4] = (i < 9);
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window();
    bus.en     = 1'b1;
    bus.spikes = 8'($urandom_range(0, 255));
    tick();
    check("busy_start", 32'(bus.busy), 32'd1);
  endtask

  // mode 5 draws random spikes and uses the bench's own counting model.
  task automatic run_window(input int mode, input logic [RW-1:0] exp_const);
    logic [7:0] pat [N];
    int c [8];
    int w, wc, t;
    for (int i = 0; i < N; i++)
      pat[i] = (mode == 5) ? 8'($urandom_range(0, 255)) : spike_for(mode, i);
    for (int l = 0; l < 8; l++) begin
      c[l] = 0;
      for (int i = 0; i < N; i++) begin
        if (pat[i][l]) begin
`ifdef SPIKE_DECODER_SATURATE_EN
          if (c[l] < 15) c[l]++;
`else
          c[l] = (c[l] + 1) % 16;
`endif
        end
      end
    end
    w = 0; wc = 0; t = 0;
    for (int l = 0; l < 8; l++) begin
      if (c[l] > wc) begin w = l; wc = c[l]; end
      t += c[l];
    end
    exp_q.push_back((mode == 5) ? pack(w, wc, t) : exp_const);
    for (int i = 0; i < N; i++) begin
      bus.spikes = pat[i];
      tick();
      if (i == 0) check("valid_low_after_report", 32'(bus.valid), 32'd0);
    end
    check("state_report", 32'(bus.state), 32'd2);
  endtask

  task automatic report(input logic en_next);
    bus.spikes = 8'hFF;
    bus.en     = en_next;
    tick();
    check("valid_pulse", 32'(bus.valid), 32'd1);
    check("busy_after_report", 32'(bus.busy), 32'(en_next));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.en     = 1'b0;
    bus.spikes = 8'h00;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_winner", 32'(bus.winner), 32'd0);
    check("rst_count",  32'(bus.winner_count), 32'd0);
    check("rst_total",  32'(bus.total), 32'd0);
    check("rst_valid",  32'(bus.valid), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_state",  32'(bus.state), 32'd0);
    rst_n = 1'b1;

    repeat (5) begin
      bus.spikes = 8'($urandom_range(0, 255));
      tick();
    end
    check("idle_busy",  32'(bus.busy), 32'd0);
    check("idle_valid", 32'(bus.valid), 32'd0);

    // Back-to-back windows with en held high
    start_window();
    run_window(0, pack(3, 12, 20));
    report(1'b1);
    run_window(0, pack(3, 12, 20));
    report(1'b1);
    @(negedge clk);
    #1;
    check("valid_period", 32'(last_valid - prev_valid), 32'd17);
    run_window(1, pack(1, 5, 10));
    report(1'b1);
    run_window(2, pack(0, 0, 0));
    report(1'b1);
    run_window(3, OVF_EXP);
    report(1'b0);

    // Abort after 7 samples of lane 2
    start_window();
    for (int i = 0; i < 7; i++) begin
      bus.spikes = 8'h04;
      tick();
    end
    bus.en     = 1'b0;
    bus.spikes = 8'h04;
    tick();
    check("abort_busy",   32'(bus.busy), 32'd0);
    check("abort_valid",  32'(bus.valid), 32'd0);
    check("hold_winner",  32'(bus.winner), 32'(OVF_EXP[13:11]));
    check("hold_count",   32'(bus.winner_count), 32'(OVF_EXP[10:7]));
    check("hold_total",   32'(bus.total), 32'(OVF_EXP[6:0]));
    repeat (3) tick();
    check("abort_idle_valid", 32'(bus.valid), 32'd0);

    start_window();
    run_window(4, pack(4, 9, 9));
    report(1'b1);
    for (int k = 0; k < 3; k++) begin
      run_window(5, '0);
      report(k != 2);
    end

    // Asynchronous reset in the middle of ACCUM
    start_window();
    repeat (5) begin
      bus.spikes = 8'hFF;
      tick();
    end
    #3;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1;
    check("mid_rst_winner", 32'(bus.winner), 32'd0);
    check("mid_rst_count",  32'(bus.winner_count), 32'd0);
    check("mid_rst_total",  32'(bus.total), 32'd0);
    check("mid_rst_valid",  32'(bus.valid), 32'd0);
    check("mid_rst_busy",   32'(bus.busy), 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_state", 32'(bus.state), 32'd0);
    check("post_rst_busy",  32'(bus.busy), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("valid_count", 32'(valids_seen), 32'd9);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder for the spike output bus of the LIF/RNN neuron core: samples an 8-lane spike vector every clock, counts spikes per lane over a fixed window, and reports the most active lane, its count and the total count. It is the readout side of the current-in/spikes-out path. It sits between the neuron's 8-bit spike output and the board-facing output pins or the bidirectional bus.

## Interface
- `WINDOW_LOG2`, default 4: window length N = 2^WINDOW_LOG2 sample cycles (16 by default).
- `CNT_W`, default 4: width of each per-lane counter.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: decode enable; high runs windows back-to-back, low aborts and idles.
- `spikes` input 8: spike vector; bit i = 1 means lane i spiked this cycle.
- `winner` output 3: index of the lane with the highest count in the last completed window.
- `winner_count` output CNT_W: count of `winner`.
- `total` output CNT_W+3: sum of all 8 lane counts, as stored after saturation or wrap.
- `valid` output 1: one-cycle pulse; the three result outputs were updated on this edge.
- `busy` output 1: high in ACCUM and REPORT.

## Operation
- States are IDLE, ACCUM and REPORT.
- On reset: state IDLE, all lane counters 0, sample counter 0, `winner`=0, `winner_count`=0, `total`=0, `valid`=0, `busy`=0.
- **IDLE:** when `en`=1 at an edge, go to ACCUM and clear the counters. `spikes` at that edge is not counted.
- **ACCUM:** at each edge, every lane counter adds its `spikes` bit and the sample counter increments. The edge that takes sample N moves the block to REPORT.
- **REPORT (one cycle):**
  - At the edge, register `winner`, `winner_count` and `total` from the current counters and set `valid`=1.
  - Clear all counters.
  - Go to ACCUM if `en`=1, otherwise to IDLE.
  - `spikes` during the REPORT cycle is discarded.
- **Argmax:** combinational over the 8 counters, on a strict greater-than compare scanned from lane 0 upward.
  - On a tie, the lowest index wins.
  - If all counts are 0, the result is `winner`=0, `winner_count`=0.
- **`en`=0 during ACCUM:** at that edge, go to IDLE and clear the counters. No `valid` pulse. The result outputs keep their last values.
- **`en`=0 during REPORT:** the report still completes with `valid`=1, then the block goes to IDLE.
- **Result hold:** the result outputs hold between reports. Only REPORT or reset changes them.
- **Mid-operation reset:** immediately returns the block to the reset values, regardless of state.
- **`total` width:** CNT_W+3 bits, so the sum of 8 lane counts never overflows.

## Timing
- Edge E0: `en` is sampled high in IDLE.
- Edges E1..EN: spike samples. EN enters REPORT.
- Edge EN+1: results are registered and `valid`=1 during cycle EN+1..EN+2.
- With `en` held high, the window period is N+1 cycles, so `valid` pulses every 17 cycles by default. The next window samples at edges EN+2..E2N+1.
- `busy` rises at E0 and falls at the edge that enters IDLE.
- `valid` is never asserted for two consecutive cycles.

## Configuration
- Macro `SPIKE_DECODER_SATURATE_EN`.
- **Defined:** each lane counter saturates at 2^CNT_W−1. Further spikes in that window are ignored.
- **Undefined:** each lane counter wraps modulo 2^CNT_W.
- In both builds, argmax and `total` use the stored (saturated or wrapped) counts.

## Test plan
All cases use the defaults: N=16, CNT_W=4.
- **Reset:** assert `rst_n`=0 mid-ACCUM with spikes active → all outputs 0 asynchronously. After release, the block is in IDLE and stays idle until `en` is high.
- **Basic window, back-to-back:**
  - Stimulus: `en` held high; lane 3 spikes on 12 of 16 samples, lane 5 on 8; REPORT-cycle spikes set to 8'hFF.
  - Required: `winner`=3, `winner_count`=12, `total`=20, `valid` one cycle at EN+1.
  - Required for a second identical window: `valid` again exactly 17 cycles later with identical results, which proves the REPORT-cycle spikes were dropped.
- **Tie:** lanes 1 and 6 each spike 5 times, others 0 → `winner`=1, `winner_count`=5, `total`=10.
- **Empty window:** `spikes`=0 throughout → `valid` pulses with `winner`=0, `winner_count`=0, `total`=0.
- **Abort:**
  - Stimulus: drop `en` after sample 7 of a window containing lane 2 spikes.
  - Required: no `valid`, previous results held, `busy`=0.
  - Stimulus: re-enable with lane 4 spiking 9 times.
  - Required: `winner`=4, `winner_count`=9, `total`=9, with no carry-over from the aborted window.
- **Overflow:** lane 0 spikes on all 16 samples, others 0.
  - With the macro: `winner_count`=15, `total`=15.
  - Without the macro: lane 0 wraps to 0, giving `winner`=0, `winner_count`=0, `total`=0.
